stopwatch: RTL and testbench

- Count-up stopwatch: the opposite-direction companion to the countdown timer.
- Accumulates elapsed hours/minutes/seconds from zero while running, with pause, resume, clear and lap capture.
- An internal prescaler turns the system clock into 1-second ticks; outputs feed the display mux in the same hours/mins/secs widths as the timer.
- Saturates at the maximum count and flags overflow.

---
 rtl/stopwatch.sv | 144 ++++++++++++++
 tb/tb_stopwatch.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch.sv
// Count-up hours/minutes/seconds stopwatch with pause, clear, lap capture and
// saturation at MAX_HOURS:59:59. An internal prescaler derives the 1 s tick.
module stopwatch #(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned MAX_HOURS     = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [4:0] hours_o,
    output logic [5:0] mins_o,
    output logic [5:0] secs_o,
    output logic [4:0] lap_hours_o,
    output logic [5:0] lap_mins_o,
    output logic [5:0] lap_secs_o,
    output logic       lap_valid_o,
    output logic       running_o,
    output logic       overflow_o
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [4:0] HOURS_MAX = 5'(MAX_HOURS);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hours_q, hours_d, lap_hours_q, lap_hours_d;
    logic [5:0]    mins_q, mins_d, lap_mins_q, lap_mins_d;
    logic [5:0]    secs_q, secs_d, lap_secs_q, lap_secs_d;
    logic          lap_valid_q, lap_valid_d;
    logic          at_max;

    assign at_max = (hours_q == HOURS_MAX) && (mins_q == 6'd59) && (secs_q == 6'd59);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        hours_d     = hours_q;
        mins_d      = mins_q;
        secs_d      = secs_q;
        lap_hours_d = lap_hours_q;
        lap_mins_d  = lap_mins_q;
        lap_secs_d  = lap_secs_q;
        lap_valid_d = lap_valid_q;

        if (clear) begin
            state_d     = StIdle;
            presc_d     = '0;
            hours_d     = '0;
            mins_d      = '0;
            secs_d      = '0;
            lap_hours_d = '0;
            lap_mins_d  = '0;
            lap_secs_d  = '0;
            lap_valid_d = 1'b0;
        end else begin
            // Lap captures the count as currently displayed, before any tick this cycle.
            if (lap && (state_q != StIdle)) begin
                lap_hours_d = hours_q;
                lap_mins_d  = mins_q;
                lap_secs_d  = secs_q;
                lap_valid_d = 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        state_d = StRun;
                        presc_d = '0;
                    end
                end
                StRun: begin
                    if (stop) begin
                        state_d = StPause;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (at_max) begin
                            state_d = StDone;
                        end else if (secs_q == 6'd59) begin
                            secs_d = '0;
                            if (mins_q == 6'd59) begin
                                mins_d  = '0;
                                hours_d = hours_q + 5'd1;
                            end else begin
                                mins_d = mins_q + 6'd1;
                            end
                        end else begin
                            secs_d = secs_q + 6'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                StPause: begin
                    if (start && !stop) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            hours_q     <= '0;
            mins_q      <= '0;
            secs_q      <= '0;
            lap_hours_q <= '0;
            lap_mins_q  <= '0;
            lap_secs_q  <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            hours_q     <= hours_d;
            mins_q      <= mins_d;
            secs_q      <= secs_d;
            lap_hours_q <= lap_hours_d;
            lap_mins_q  <= lap_mins_d;
            lap_secs_q  <= lap_secs_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign hours_o     = hours_q;
    assign mins_o      = mins_q;
    assign secs_o      = secs_q;
    assign lap_hours_o = lap_hours_q;
    assign lap_mins_o  = lap_mins_q;
    assign lap_secs_o  = lap_secs_q;
    assign lap_valid_o = lap_valid_q;
    assign running_o   = (state_q == StRun);
    assign overflow_o  = (state_q == StDone);

endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch: a 4-ticks/s instance and a 1 Hz instance with
// MAX_HOURS=1, sharing clock and reset.
module tb_stopwatch;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Instance a: TICKS_PER_SEC=4, MAX_HOURS=23
    logic       a_start, a_stop, a_clear, a_lap;
    logic [4:0] a_hours, a_lap_hours;
    logic [5:0] a_mins, a_secs, a_lap_mins, a_lap_secs;
    logic       a_lap_valid, a_running, a_overflow;

    // Instance b: TICKS_PER_SEC=1, MAX_HOURS=1
    logic       b_start, b_stop, b_clear, b_lap;
    logic [4:0] b_hours, b_lap_hours;
    logic [5:0] b_mins, b_secs, b_lap_mins, b_lap_secs;
    logic       b_lap_valid, b_running, b_overflow;

    stopwatch #(.TICKS_PER_SEC(4), .MAX_HOURS(23)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .clear(a_clear),
        .lap(a_lap), .hours_o(a_hours), .mins_o(a_mins), .secs_o(a_secs),
        .lap_hours_o(a_lap_hours), .lap_mins_o(a_lap_mins), .lap_secs_o(a_lap_secs),
        .lap_valid_o(a_lap_valid), .running_o(a_running), .overflow_o(a_overflow)
    );

    stopwatch #(.TICKS_PER_SEC(1), .MAX_HOURS(1)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .clear(b_clear),
        .lap(b_lap), .hours_o(b_hours), .mins_o(b_mins), .secs_o(b_secs),
        .lap_hours_o(b_lap_hours), .lap_mins_o(b_lap_mins), .lap_secs_o(b_lap_secs),
        .lap_valid_o(b_lap_valid), .running_o(b_running), .overflow_o(b_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {a_start, a_stop, a_clear, a_lap} = '0;
        {b_start, b_stop, b_clear, b_lap} = '0;
        #2;
        checks++;
        if ({a_hours, a_mins, a_secs} !== 17'd0) begin
            errors++; $display("FAIL reset_count: got %h expected 0", {a_hours, a_mins, a_secs});
        end
        checks++;
        if ({a_lap_hours, a_lap_mins, a_lap_secs, a_lap_valid, a_running, a_overflow} !== 20'd0) begin
            errors++; $display("FAIL reset_flags_a: got %h expected 0",
                {a_lap_hours, a_lap_mins, a_lap_secs, a_lap_valid, a_running, a_overflow});
        end
        checks++;
        if ({b_hours, b_mins, b_secs, b_lap_valid, b_running, b_overflow} !== 20'd0) begin
            errors++; $display("FAIL reset_b: got %h expected 0",
                {b_hours, b_mins, b_secs, b_lap_valid, b_running, b_overflow});
        end
        #5 reset = 1'b1;
        step(3);
        checks++;
        if ({a_running, a_secs, b_running, b_secs} !== 14'd0) begin
            errors++; $display("FAIL idle_after_reset: got %h expected 0",
                {a_running, a_secs, b_running, b_secs});
        end
    endtask

    task automatic test_count();
        a_start = 1'b1; step(1); a_start = 1'b0;
        checks++;
        if (a_running !== 1'b1) begin
            errors++; $display("FAIL count_running: got %b expected 1", a_running);
        end
        step(3);
        checks++;
        if (a_secs !== 6'd0) begin
            errors++; $display("FAIL count_3clk: got %0d expected 0", a_secs);
        end
        step(1);
        checks++;
        if (a_secs !== 6'd1) begin
            errors++; $display("FAIL count_4clk: got %0d expected 1", a_secs);
        end
        step(3);
        checks++;
        if (a_secs !== 6'd1 || a_running !== 1'b1) begin
            errors++; $display("FAIL count_7clk: got secs=%0d run=%b expected 1/1", a_secs, a_running);
        end
        step(1);
        checks++;
        if (a_secs !== 6'd2) begin
            errors++; $display("FAIL count_8clk: got %0d expected 2", a_secs);
        end
        a_clear = 1'b1; step(1); a_clear = 1'b0;
    endtask

    task automatic test_pause();
        a_start = 1'b1; step(1); a_start = 1'b0;
        step(6);
        a_stop = 1'b1; step(5); a_stop = 1'b0;
        checks++;
        if (a_secs !== 6'd1 || a_running !== 1'b0) begin
            errors++; $display("FAIL pause_hold: got secs=%0d run=%b expected 1/0", a_secs, a_running);
        end
        a_start = 1'b1; step(1); a_start = 1'b0;
        checks++;
        if (a_running !== 1'b1 || a_secs !== 6'd1) begin
            errors++; $display("FAIL resume: got secs=%0d run=%b expected 1/1", a_secs, a_running);
        end
        step(1);
        checks++;
        if (a_secs !== 6'd1) begin
            errors++; $display("FAIL resume_1clk: got %0d expected 1", a_secs);
        end
        step(1);
        checks++;
        if (a_secs !== 6'd2) begin
            errors++; $display("FAIL resume_2clk: got %0d expected 2", a_secs);
        end
        a_clear = 1'b1; step(1); a_clear = 1'b0;
    endtask

    task automatic test_stop_clear();
        a_start = 1'b1; step(1); a_start = 1'b0;
        step(20);
        checks++;
        if (a_secs !== 6'd5) begin
            errors++; $display("FAIL sc_pre: got %0d expected 5", a_secs);
        end
        a_stop = 1'b1; a_clear = 1'b1; step(1); a_stop = 1'b0; a_clear = 1'b0;
        checks++;
        if ({a_hours, a_mins, a_secs, a_running, a_overflow} !== 19'd0) begin
            errors++; $display("FAIL stop_clear: got %h expected 0",
                {a_hours, a_mins, a_secs, a_running, a_overflow});
        end
        a_start = 1'b1; a_stop = 1'b1; step(1); a_start = 1'b0; a_stop = 1'b0;
        checks++;
        if (a_running !== 1'b0) begin
            errors++; $display("FAIL start_stop_idle: got run=%b expected 0", a_running);
        end
        step(4);
        checks++;
        if (a_secs !== 6'd0 || a_running !== 1'b0) begin
            errors++; $display("FAIL start_stop_idle_hold: got secs=%0d run=%b expected 0/0",
                a_secs, a_running);
        end
    endtask

    task automatic test_overflow();
        b_start = 1'b1; step(1); b_start = 1'b0;
        step(3599);
        checks++;
        if ({b_hours, b_mins, b_secs} !== {5'd0, 6'd59, 6'd59}) begin
            errors++; $display("FAIL ovf_0_59_59: got %0d:%0d:%0d expected 0:59:59", b_hours, b_mins, b_secs);
        end
        step(1);
        checks++;
        if ({b_hours, b_mins, b_secs} !== {5'd1, 6'd0, 6'd0}) begin
            errors++; $display("FAIL ovf_1_00_00: got %0d:%0d:%0d expected 1:0:0", b_hours, b_mins, b_secs);
        end
        step(3599);
        checks++;
        if ({b_hours, b_mins, b_secs, b_running, b_overflow} !== {5'd1, 6'd59, 6'd59, 1'b1, 1'b0}) begin
            errors++; $display("FAIL ovf_1_59_59: got %0d:%0d:%0d run=%b ovf=%b expected 1:59:59 1/0",
                b_hours, b_mins, b_secs, b_running, b_overflow);
        end
        step(1);
        checks++;
        if ({b_hours, b_mins, b_secs, b_running, b_overflow} !== {5'd1, 6'd59, 6'd59, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ovf_saturate: got %0d:%0d:%0d run=%b ovf=%b expected 1:59:59 0/1",
                b_hours, b_mins, b_secs, b_running, b_overflow);
        end
        b_start = 1'b1; step(2); b_start = 1'b0;
        checks++;
        if ({b_hours, b_mins, b_secs, b_running, b_overflow} !== {5'd1, 6'd59, 6'd59, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ovf_start_ignored: got %0d:%0d:%0d run=%b ovf=%b expected 1:59:59 0/1",
                b_hours, b_mins, b_secs, b_running, b_overflow);
        end
        b_clear = 1'b1; step(1); b_clear = 1'b0;
        checks++;
        if ({b_hours, b_mins, b_secs, b_running, b_overflow} !== 19'd0) begin
            errors++; $display("FAIL ovf_clear: got %h expected 0",
                {b_hours, b_mins, b_secs, b_running, b_overflow});
        end
    endtask

    task automatic test_lap();
        b_lap = 1'b1; step(1); b_lap = 1'b0;
        checks++;
        if (b_lap_valid !== 1'b0) begin
            errors++; $display("FAIL lap_idle: got valid=%b expected 0", b_lap_valid);
        end
        b_start = 1'b1; step(1); b_start = 1'b0;
        step(7);
        b_lap = 1'b1; step(1); b_lap = 1'b0;
        checks++;
        if (b_lap_secs !== 6'd7 || b_lap_valid !== 1'b1 || b_secs !== 6'd8) begin
            errors++; $display("FAIL lap_first: got lap=%0d valid=%b secs=%0d expected 7/1/8",
                b_lap_secs, b_lap_valid, b_secs);
        end
        step(1);
        checks++;
        if (b_lap_secs !== 6'd7 || b_secs !== 6'd9) begin
            errors++; $display("FAIL lap_hold: got lap=%0d secs=%0d expected 7/9", b_lap_secs, b_secs);
        end
        step(3);
        b_lap = 1'b1; step(1); b_lap = 1'b0;
        checks++;
        if (b_lap_secs !== 6'd12 || b_secs !== 6'd13) begin
            errors++; $display("FAIL lap_second: got lap=%0d secs=%0d expected 12/13", b_lap_secs, b_secs);
        end
        b_clear = 1'b1; step(1); b_clear = 1'b0;
        checks++;
        if ({b_lap_hours, b_lap_mins, b_lap_secs, b_lap_valid, b_secs} !== 24'd0) begin
            errors++; $display("FAIL lap_clear: got %h expected 0",
                {b_lap_hours, b_lap_mins, b_lap_secs, b_lap_valid, b_secs});
        end
    endtask

    task automatic test_async_reset();
        a_start = 1'b1; step(1); a_start = 1'b0;
        step(599);
        a_lap = 1'b1; step(1); a_lap = 1'b0;
        checks++;
        if ({a_mins, a_secs, a_lap_mins, a_lap_secs, a_lap_valid} !== {6'd2, 6'd30, 6'd2, 6'd29, 1'b1}) begin
            errors++; $display("FAIL ar_pre: got %0d:%0d lap %0d:%0d v=%b expected 2:30 lap 2:29 v=1",
                a_mins, a_secs, a_lap_mins, a_lap_secs, a_lap_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({a_hours, a_mins, a_secs, a_lap_mins, a_lap_secs, a_lap_valid, a_running} !== 31'd0) begin
            errors++; $display("FAIL ar_immediate: got %h expected 0",
                {a_hours, a_mins, a_secs, a_lap_mins, a_lap_secs, a_lap_valid, a_running});
        end
        #3 reset = 1'b1;
        step(6);
        checks++;
        if (a_running !== 1'b0 || a_secs !== 6'd0 || a_overflow !== 1'b0) begin
            errors++; $display("FAIL ar_idle: got run=%b secs=%0d ovf=%b expected 0/0/0",
                a_running, a_secs, a_overflow);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count();
        test_pause();
        test_stop_clear();
        test_overflow();
        test_lap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
